timer_regs: RTL

- Memory-mapped responder for the DMG timer registers DIV, TIMA, TMA and TAC, at FF04–FF07.
- Attaches to the CPU data bus in parallel with `memory` and uses the same rd/wr port signature.
- The top-level read mux selects this block's read data when `o_rd_hit` is high.
- Generates the timer interrupt request pulse for the future interrupt controller.

---
 rtl/timer_regs.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/timer_regs.sv
`timescale 1ns/1ps
// timer_regs
// Memory-mapped DMG timer block: DIV, TIMA, TMA and TAC at BASE_ADDR..BASE_ADDR+3.
// It sits on the CPU bus next to the main memory. The top-level read mux takes
// o_mem_rd_data whenever o_rd_hit is high. o_irq is a one-cycle request for the
// interrupt controller.
//
// Build option TIMER_OVF_DELAY_EN:
//   defined   - after TIMA overflows it reads 00 for four cycles. It is then reloaded
//               from TMA, and o_irq is high in the same cycle as the reload.
//   undefined - an overflow loads TMA on the same edge, and o_irq pulses one cycle
//               later. A TIMA write in that cycle suppresses the pulse.
//
// state       | meaning
// IDLE        | TIMA counting on falling edges of the selected divider bit
// RELOAD_WAIT | TIMA overflowed; reloads from TMA when ovf_cnt reaches 0
//               (present only when TIMER_OVF_DELAY_EN is defined)

module timer_regs #(
  parameter logic [15:0] BASE_ADDR = 16'hFF04
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_mem_rd_addr,
  input  logic        i_mem_wr_en,
  input  logic [15:0] i_mem_wr_addr,
  input  logic [7:0]  i_mem_wr_data,
  output logic [7:0]  o_mem_rd_data,
  output logic        o_rd_hit,
  output logic        o_irq
);

  logic [15:0] sys_cnt;
  logic [15:0] sys_cnt_nxt;
  logic [7:0]  tima;
  logic [7:0]  tma;
  logic [7:0]  tma_nxt;
  logic [2:0]  tac;
  logic [2:0]  tac_nxt;
  logic        prev_edge_bit;
  logic        sel_bit;
  logic        edge_bit;
  logic        tick;

  logic [15:0] wr_off;
  logic        wr_hit;
  logic        wr_div;
  logic        wr_tima;
  logic        wr_tma;
  logic        wr_tac;

  logic [15:0] rd_off;
  logic        rd_hit;

  // Decode CPU writes into per-register strobes.
  always_comb begin
    wr_off  = i_mem_wr_addr - BASE_ADDR;
    wr_hit  = i_mem_wr_en && (wr_off[15:2] == 14'd0);
    wr_div  = wr_hit && (wr_off[1:0] == 2'd0);
    wr_tima = wr_hit && (wr_off[1:0] == 2'd1);
    wr_tma  = wr_hit && (wr_off[1:0] == 2'd2);
    wr_tac  = wr_hit && (wr_off[1:0] == 2'd3);
  end

  // Values after this edge. The edge detector looks at these post-write values, so
  // DIV and TAC writes can produce a falling edge and bump TIMA.
  always_comb begin
    sys_cnt_nxt = wr_div ? 16'h0000 : sys_cnt + 16'd1;
    tac_nxt     = wr_tac ? i_mem_wr_data[2:0] : tac;
    tma_nxt     = wr_tma ? i_mem_wr_data : tma;
    sel_bit     = 1'b0;
    case (tac_nxt[1:0])
      2'b00:   sel_bit = sys_cnt_nxt[9];
      2'b01:   sel_bit = sys_cnt_nxt[3];
      2'b10:   sel_bit = sys_cnt_nxt[5];
      default: sel_bit = sys_cnt_nxt[7];
    endcase
    edge_bit = tac_nxt[2] & sel_bit;
    tick     = prev_edge_bit & ~edge_bit;
  end

  // Zero-latency read mux.
  always_comb begin
    rd_off        = i_mem_rd_addr - BASE_ADDR;
    rd_hit        = (rd_off[15:2] == 14'd0);
    o_mem_rd_data = 8'h00;
    if (rd_hit) begin
      case (rd_off[1:0])
        2'd0:    o_mem_rd_data = sys_cnt[15:8];
        2'd1:    o_mem_rd_data = tima;
        2'd2:    o_mem_rd_data = tma;
        default: o_mem_rd_data = {5'b11111, tac};
      endcase
    end
    o_rd_hit = rd_hit;
  end

  // Free-running divider, configuration registers and edge history.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sys_cnt       <= 16'h0000;
      tac           <= 3'b000;
      tma           <= 8'h00;
      prev_edge_bit <= 1'b0;
    end else begin
      sys_cnt       <= sys_cnt_nxt;
      tac           <= tac_nxt;
      tma           <= tma_nxt;
      prev_edge_bit <= edge_bit;
    end
  end

`ifdef TIMER_OVF_DELAY_EN

  typedef enum logic [0:0] {
    IDLE        = 1'b0,
    RELOAD_WAIT = 1'b1
  } state_t;

  state_t     state;
  logic [1:0] ovf_cnt;

  // TIMA counter with a delayed overflow reload. ovf_cnt counts down to the reload edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      ovf_cnt <= 2'd0;
      tima    <= 8'h00;
      o_irq   <= 1'b0;
    end else begin
      o_irq <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_tima) begin
            tima <= i_mem_wr_data;
          end else if (tick) begin
            if (tima == 8'hFF) begin
              tima    <= 8'h00;
              ovf_cnt <= 2'd3;
              state   <= RELOAD_WAIT;
            end else begin
              tima <= tima + 8'd1;
            end
          end
        end
        RELOAD_WAIT: begin
          if (ovf_cnt == 2'd0) begin
            // The reload edge: TMA (including a same-cycle write) beats a TIMA write.
            tima  <= tma_nxt;
            o_irq <= 1'b1;
            state <= IDLE;
          end else begin
            ovf_cnt <= ovf_cnt - 2'd1;
            if (wr_tima) begin
              // A CPU write during the wait cancels the pending reload and the irq.
              tima    <= i_mem_wr_data;
              ovf_cnt <= 2'd0;
              state   <= IDLE;
            end else if (tick) begin
              tima <= tima + 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`else

  logic irq_pend;

  // TIMA counter with an immediate reload; the irq follows one cycle later unless
  // a TIMA write lands in that cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tima     <= 8'h00;
      irq_pend <= 1'b0;
      o_irq    <= 1'b0;
    end else begin
      o_irq    <= irq_pend & ~wr_tima;
      irq_pend <= 1'b0;
      if (wr_tima) begin
        tima <= i_mem_wr_data;
      end else if (tick) begin
        if (tima == 8'hFF) begin
          tima     <= tma_nxt;
          irq_pend <= 1'b1;
        end else begin
          tima <= tima + 8'd1;
        end
      end
    end
  end

`endif

endmodule
